// File: rtl/instruction_fetch.sv
// Fetch stage: issues one instruction-memory request at a time from the current PC,
// queues returned instructions with their PCs for decode, and handles redirect flushes.
module instruction_fetch #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned QUEUE_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    output logic                  pc_write,
    output logic [ADDR_WIDTH-1:0] next_pc,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_resp_valid,
    input  logic [DATA_WIDTH-1:0] imem_resp_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  if_valid,
    input  logic                  if_ready,
    output logic [DATA_WIDTH-1:0] if_instr,
    output logic [ADDR_WIDTH-1:0] if_pc
);

    localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [CNT_W-1:0]      count;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [DATA_WIDTH-1:0] instr_q [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0] pc_q    [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0] req_pc;
    logic                  handshake;
    logic                  push;
    logic                  pop;
    logic                  unused_redirect_lsbs;

    // Redirect targets are word aligned; the low bits are deliberately ignored.
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign imem_req_addr = pc_in;
    assign if_valid      = (count != '0);
    assign if_instr      = instr_q[rd_ptr];
    assign if_pc         = pc_q[rd_ptr];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; redirect takes priority, and a response in the same cycle retires it.
    always_comb begin
        state_nxt = state;
        if (redirect_valid) begin
            case (state)
                S_WAIT:  state_nxt = imem_resp_valid ? S_REQ : S_DROP;
                S_DROP:  state_nxt = imem_resp_valid ? S_REQ : S_DROP;
                default: state_nxt = S_REQ;
            endcase
        end else begin
            case (state)
                S_REQ:   state_nxt = handshake ? S_WAIT : S_REQ;
                S_WAIT:  state_nxt = imem_resp_valid ? S_REQ : S_WAIT;
                S_DROP:  state_nxt = imem_resp_valid ? S_REQ : S_DROP;
                default: state_nxt = S_REQ;
            endcase
        end
    end

    // Output logic: request gating, PC update and queue push/pop strobes.
    always_comb begin
        imem_req_valid = 1'b0;
        handshake      = 1'b0;
        pc_write       = 1'b0;
        next_pc        = '0;
        push           = 1'b0;
        pop            = 1'b0;
        if (!rst) begin
            if (redirect_valid) begin
                pc_write = 1'b1;
                next_pc  = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
            end else begin
                // In REQ nothing is in flight, so a free slot guarantees room for the response.
                imem_req_valid = (state == S_REQ) && (count < CNT_W'(QUEUE_DEPTH));
                handshake      = imem_req_valid && imem_req_ready;
                if (handshake) begin
                    pc_write = 1'b1;
                    next_pc  = pc_in + ADDR_WIDTH'(4);
                end
                push = (state == S_WAIT) && imem_resp_valid;
                pop  = if_valid && if_ready;
            end
        end
    end

    // Fetch queue and outstanding-request PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            req_pc <= '0;
            for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else if (redirect_valid) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (handshake) begin
                req_pc <= pc_in;
            end
            if (push) begin
                instr_q[wr_ptr] <= imem_resp_data;
                pc_q[wr_ptr]    <= req_pc;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: PC register and memory models around the DUT,
// scoreboard of expected (pc, instr) pairs checked by a decoupled decode-side monitor.
module tb_instruction_fetch;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [DW-1:0] instr;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] pc_in;
    logic          pc_write;
    logic [AW-1:0] next_pc;
    logic          imem_req_valid;
    logic          imem_req_ready;
    logic [AW-1:0] imem_req_addr;
    logic          imem_resp_valid;
    logic [DW-1:0] imem_resp_data;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          if_valid;
    logic          if_ready;
    logic [DW-1:0] if_instr;
    logic [AW-1:0] if_pc;

    // Bench-side models
    logic [AW-1:0] pc_reg;
    logic          pc_load;
    logic [AW-1:0] pc_load_val;
    logic          pend;
    logic [AW-1:0] pend_addr;
    int            wait_cnt;
    int            lat;
    int            hs_cnt;
    int            hs_limit;
    logic          ready_en;
    logic          mem_clr;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    instruction_fetch #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .QUEUE_DEPTH(2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_in          (pc_in),
        .pc_write       (pc_write),
        .next_pc        (next_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc)
    );

    always #5 clk = ~clk;

    // Program counter model
    assign pc_in = pc_reg;
    always @(posedge clk) begin
        if (pc_load)       pc_reg <= pc_load_val;
        else if (pc_write) pc_reg <= next_pc;
    end

    // Memory model: fixed latency, instruction = 0xC0DE0000 ^ address
    assign imem_req_ready  = ready_en && (hs_cnt < hs_limit);
    assign imem_resp_valid = pend && (wait_cnt == 0);
    assign imem_resp_data  = 32'hC0DE_0000 ^ pend_addr;
    always @(posedge clk) begin
        if (mem_clr) begin
            pend     <= 1'b0;
            hs_cnt   <= 0;
            wait_cnt <= 0;
        end else begin
            if (imem_resp_valid)            pend     <= 1'b0;
            else if (pend && wait_cnt != 0) wait_cnt <= wait_cnt - 1;
            if (imem_req_valid && imem_req_ready) begin
                pend      <= 1'b1;
                pend_addr <= imem_req_addr;
                wait_cnt  <= lat;
                hs_cnt    <= hs_cnt + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic expect_pair(input logic [AW-1:0] pc, input logic [DW-1:0] instr);
        exp_t e;
        e.pc    = pc;
        e.instr = instr;
        exp_q.push_back(e);
    endtask

    // Decode-side monitor: every accepted head entry must match the scoreboard front.
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (if_valid === 1'b1 && if_ready === 1'b1 && redirect_valid === 1'b0) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL decode_unexpected: got pc=%h instr=%h, required no entry", if_pc, if_instr);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (if_pc !== e.pc || if_instr !== e.instr) begin
                        miscompares++;
                        $display("FAIL decode_entry: got pc=%h instr=%h, required pc=%h instr=%h",
                                 if_pc, if_instr, e.pc, e.instr);
                    end
                end
            end
        end
    endtask

    task automatic do_reset(input logic [AW-1:0] pc0);
        rst            = 1'b1;
        mem_clr        = 1'b1;
        pc_load        = 1'b1;
        pc_load_val    = pc0;
        redirect_valid = 1'b0;
        tick();
        pc_load = 1'b0;
        mem_clr = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("drain_remaining", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic expect_req(input string name, input logic [AW-1:0] addr, input int budget);
        bit found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (imem_req_valid === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: got no request, required request to %h", name, addr);
        end else begin
            check(name, imem_req_addr, addr);
        end
    endtask

    initial begin
        bit seen;
        rst            = 1'b1;
        mem_clr        = 1'b1;
        pc_load        = 1'b1;
        pc_load_val    = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if_ready       = 1'b0;
        ready_en       = 1'b0;
        hs_limit       = 0;
        lat            = 0;
        fork
            monitor();
        join_none

        // Reset values
        tick();
        pc_load = 1'b0;
        @(negedge clk);
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_if_instr", if_instr, 32'h0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_pc_write", 32'(pc_write), 32'd0);
        check("rst_next_pc", next_pc, 32'h0);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_req_addr", imem_req_addr, 32'h0);

        // Sequential fetch, zero-wait memory, decode ready
        ready_en = 1'b1; if_ready = 1'b1; hs_limit = 3; lat = 0;
        expect_pair(32'h0, 32'hC0DE_0000);
        expect_pair(32'h4, 32'hC0DE_0004);
        expect_pair(32'h8, 32'hC0DE_0008);
        do_reset(32'h0);
        @(negedge clk);
        check("seq_req_valid", 32'(imem_req_valid), 32'd1);
        check("seq_req_addr", imem_req_addr, 32'h0);
        check("seq_next_pc", next_pc, 32'h4);
        @(negedge clk);
        check("seq_if_valid_n1", 32'(if_valid), 32'd0);
        @(negedge clk);
        check("seq_if_valid_n2", 32'(if_valid), 32'd1);
        wait_drain(40);

        // Decode stalled: queue fills to depth, then drains in order and fetch resumes
        if_ready = 1'b0; hs_limit = 3;
        expect_pair(32'h0, 32'hC0DE_0000);
        expect_pair(32'h4, 32'hC0DE_0004);
        expect_pair(32'h8, 32'hC0DE_0008);
        do_reset(32'h0);
        repeat (10) tick();
        @(negedge clk);
        check("stall_issued", 32'(hs_cnt), 32'd2);
        check("stall_req_valid", 32'(imem_req_valid), 32'd0);
        check("stall_head_pc", if_pc, 32'h0);
        tick();
        if_ready = 1'b1;
        wait_drain(40);

        // Memory backpressure: request held stable, PC untouched until accepted
        ready_en = 1'b0; hs_limit = 1;
        expect_pair(32'h100, 32'hC0DE_0100);
        do_reset(32'h100);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_req_valid", 32'(imem_req_valid), 32'd1);
            check("bp_req_addr", imem_req_addr, 32'h100);
            check("bp_pc_write", 32'(pc_write), 32'd0);
            tick();
        end
        ready_en = 1'b1;
        @(negedge clk);
        check("bp_accept_pc_write", 32'(pc_write), 32'd1);
        check("bp_accept_next_pc", next_pc, 32'h104);
        wait_drain(40);

        // Redirect while WAIT: late response dropped, fetch restarts at aligned target
        lat = 4; hs_limit = 2;
        expect_pair(32'h2000, 32'hC0DE_2000);
        do_reset(32'h10);
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h2002;
        @(negedge clk);
        check("rdw_pc_write", 32'(pc_write), 32'd1);
        check("rdw_next_pc", next_pc, 32'h2000);
        check("rdw_req_valid", 32'(imem_req_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("rdw_drop_req_valid", 32'(imem_req_valid), 32'd0);
        expect_req("rdw_next_req", 32'h2000, 20);
        wait_drain(40);

        // Redirect with a full queue and a pop in the same cycle
        lat = 0; if_ready = 1'b0; hs_limit = 2;
        do_reset(32'h0);
        repeat (8) tick();
        expect_pair(32'h40, 32'hC0DE_0040);
        redirect_valid = 1'b1; redirect_pc = 32'h40; if_ready = 1'b1; hs_limit = 3;
        tick();
        redirect_valid = 1'b0;
        expect_req("rdf_next_req", 32'h40, 10);
        check("rdf_flushed", 32'(if_valid), 32'd0);
        wait_drain(40);

        // Redirect in the same cycle as a response and a pop
        lat = 2; if_ready = 1'b0; hs_limit = 2;
        do_reset(32'h0);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (imem_resp_valid === 1'b1 && hs_cnt == 2) begin
                seen = 1'b1;
                break;
            end
        end
        check("rdr_resp_seen", 32'(seen), 32'd1);
        expect_pair(32'h80, 32'hC0DE_0080);
        redirect_valid = 1'b1; redirect_pc = 32'h83; if_ready = 1'b1; hs_limit = 3;
        @(negedge clk);
        check("rdr_next_pc", next_pc, 32'h80);
        tick();
        redirect_valid = 1'b0;
        expect_req("rdr_next_req", 32'h80, 10);
        check("rdr_flushed", 32'(if_valid), 32'd0);
        wait_drain(40);

        // PC wrap at top of address space
        lat = 0; hs_limit = 1;
        expect_pair(32'hFFFF_FFFC, 32'h3F21_FFFC);
        do_reset(32'hFFFF_FFFC);
        @(negedge clk);
        check("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        check("wrap_next_pc", next_pc, 32'h0);
        wait_drain(40);
        check("wrap_pc", pc_reg, 32'h0);

        // Reset during WAIT: late response after release is ignored
        pc_load = 1'b1; pc_load_val = 32'h300;
        tick();
        pc_load = 1'b0;
        lat = 3; hs_limit = hs_cnt + 1; ready_en = 1'b1;
        tick();
        rst = 1'b1; ready_en = 1'b0;
        @(negedge clk);
        check("rw_req_valid", 32'(imem_req_valid), 32'd0);
        check("rw_pc_write", 32'(pc_write), 32'd0);
        check("rw_next_pc", next_pc, 32'h0);
        check("rw_req_addr", imem_req_addr, 32'h304);
        tick();
        @(negedge clk);
        check("rw_if_valid", 32'(if_valid), 32'd0);
        check("rw_if_instr", if_instr, 32'h0);
        check("rw_if_pc", if_pc, 32'h0);
        tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (if_valid !== 1'b0) seen = 1'b1;
        end
        check("rw_late_resp_ignored", 32'(seen), 32'd0);
        lat = 0; hs_limit = hs_cnt + 1; ready_en = 1'b1;
        expect_pair(32'h304, 32'hC0DE_0304);
        wait_drain(40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage between the program counter and decode. Reads the current PC from `program_counter`, issues one instruction-memory request at a time over a valid/ready handshake, and buffers returned instructions with their PCs in a small queue for decode. Drives `pc_write`/`next_pc` back into `program_counter` for sequential advance (+4) and for branch/exception redirects, which flush all fetched-but-unconsumed work.

## Interface
- `ADDR_WIDTH`, 32, PC and memory address width
- `DATA_WIDTH`, 32, instruction width
- `QUEUE_DEPTH`, 2, fetch-queue entries (power of two, ≥2)

- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `pc_in`  in  ADDR_WIDTH  current PC (from `program_counter.pc_out`)
- `pc_write`  out  1  PC update enable (to `program_counter.pc_write`)
- `next_pc`  out  ADDR_WIDTH  PC update value (to `program_counter.next_pc`)
- `imem_req_valid`  out  1  memory request valid
- `imem_req_ready`  in  1  memory accepts request
- `imem_req_addr`  out  ADDR_WIDTH  request address
- `imem_resp_valid`  in  1  response data valid (exactly one per accepted request)
- `imem_resp_data`  in  DATA_WIDTH  returned instruction
- `redirect_valid`  in  1  flush and redirect fetch
- `redirect_pc`  in  ADDR_WIDTH  redirect target
- `if_valid`  out  1  queue head valid to decode
- `if_ready`  in  1  decode accepts head
- `if_instr`  out  DATA_WIDTH  head instruction
- `if_pc`  out  ADDR_WIDTH  PC of head instruction

## Operation
- FSM states: REQ, WAIT, DROP. At most one request outstanding.
- REQ: `imem_req_valid` = !rst && !redirect_valid && (count + 0) < QUEUE_DEPTH; `imem_req_addr` = `pc_in`. On handshake: latch `req_pc` = `pc_in`, `pc_write`=1, `next_pc`=`pc_in`+4 (mod 2^ADDR_WIDTH, wraps), go WAIT. Responses arriving in REQ are ignored.
- WAIT: on `imem_resp_valid`, push {`req_pc`, `imem_resp_data`} into queue, go REQ.
- DROP: on `imem_resp_valid`, discard data, go REQ.
- Issue gating counts the in-flight slot: request only when queue has a free slot, so a push never overflows.
- Redirect (any state, highest priority): `pc_write`=1, `next_pc`={`redirect_pc`[ADDR_WIDTH-1:2],2'b00}; queue cleared (count=0, `if_valid`=0 next cycle); sequential +4 update suppressed; `imem_req_valid` forced 0 that cycle. State: REQ→REQ; WAIT→DROP, except WAIT with `imem_resp_valid` same cycle → REQ (response discarded); DROP→DROP, except with `imem_resp_valid` same cycle → REQ.
- Queue: FIFO, `if_valid` = count≠0, `if_instr`/`if_pc` = head entry. Pop on `if_valid && if_ready`. Push and pop in same cycle allowed; count unchanged. Redirect overrides push/pop in same cycle.
- `imem_req_addr` and `imem_req_valid` stay stable while valid is held and not accepted (PC not written in that window).

## Timing
- Reset (cycle with `rst`=1): state REQ, count 0, pointers 0; outputs `if_valid`=0, `if_instr`=0, `if_pc`=0, `pc_write`=0, `next_pc`=0, `imem_req_valid`=0, `imem_req_addr`=`pc_in`. `redirect_valid` ignored during reset. Reset mid-request: outstanding response after reset released while in REQ is ignored.
- `pc_write`/`next_pc`/`imem_req_valid` are combinational from state, count and inputs; all else registered.
- Request accepted at cycle N → `pc_in` = old+4 at N+1; earliest response N+1; entry visible on `if_valid` at N+2.
- Peak throughput: one instruction per 2 cycles (zero-wait memory, decode always ready).
- Redirect at cycle N → `pc_in`=target at N+1; new request may issue at N+1 if state is REQ.

## Test plan
- Reset then sequential fetch, PC=0, memory zero-wait, decode ready: requests at 0x0,0x4,0x8; decode sees (0x0,I0),(0x4,I1),(0x8,I2), `if_valid` first high 2 cycles after first handshake.
- Decode stalled (`if_ready`=0): exactly QUEUE_DEPTH=2 entries fetched, then `imem_req_valid` stays 0; releasing `if_ready` drains in order and fetching resumes at 0x8.
- Memory backpressure: `imem_req_ready`=0 for 3 cycles with `pc_in`=0x100: `imem_req_valid`=1, address 0x100 stable, `pc_write`=0 throughout; accepted on 4th cycle with `next_pc`=0x104.
- Redirect while WAIT (req to 0x10 outstanding), target 0x2002: `next_pc`=0x2000, state DROP, late response for 0x10 never reaches decode, next request to 0x2000.
- Redirect same cycle as response and as pop with 2 queued entries: queue empty next cycle, response dropped, next request to redirect target.
- Wrap: `pc_in`=0xFFFFFFFC accepted → `next_pc`=0x00000000; assertion `rst` mid-WAIT returns all outputs to reset values next cycle.
